tpu_tile_scheduler: RTL and testbench

TPU_TILE_SCHEDULER -- requirements
Module: tpu_tile_scheduler

---
 rtl/tpu_tile_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_tpu_tile_scheduler.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_tile_scheduler.sv
// rtl/tpu_tile_scheduler.sv - walks the M x N output tiles of a matmul and launches each onto the systolic array.
// Bases advance by running accumulators; the remaining-row/col counters replace any division for tile counts.
module tpu_tile_scheduler #(
  parameter int ARRAY_SIZE = 4,
  parameter int ADDR_BITS  = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           cfg_k,
  input  logic [9:0]           cfg_m,
  input  logic [9:0]           cfg_n,
  input  logic                 tpu_busy,
  output logic                 tpu_in_valid,
  output logic [7:0]           tpu_k,
  output logic [7:0]           tpu_m,
  output logic [7:0]           tpu_n,
  output logic [ADDR_BITS-1:0] a_base,
  output logic [ADDR_BITS-1:0] b_base,
  output logic [ADDR_BITS-1:0] c_base,
  output logic [15:0]          tile_idx,
  output logic                 sched_busy,
  output logic                 done,
  output logic                 err
);

  localparam logic [9:0]           AS10   = 10'(ARRAY_SIZE);
  localparam logic [7:0]           AS8    = 8'(ARRAY_SIZE);
  localparam logic [ADDR_BITS-1:0] AS_ADR = ADDR_BITS'(ARRAY_SIZE);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, NEXT, FINISH} state_e;

  state_e               state_q, state_d;
  logic [7:0]           k_q, k_d;
  logic [9:0]           n_q, n_d;
  logic [9:0]           rem_m_q, rem_m_d;
  logic [9:0]           rem_n_q, rem_n_d;
  logic                 zero_q, zero_d;
  logic [3:0]           ack_cnt_q, ack_cnt_d;
  logic                 err_q, err_d;
  logic [7:0]           tpu_m_q, tpu_m_d;
  logic [7:0]           tpu_n_q, tpu_n_d;
  logic [ADDR_BITS-1:0] a_base_q, a_base_d;
  logic [ADDR_BITS-1:0] b_base_q, b_base_d;
  logic [ADDR_BITS-1:0] c_base_q, c_base_d;
  logic [15:0]          tile_idx_q, tile_idx_d;

  logic [9:0] rem_m_step;
  logic [9:0] rem_n_step;
  logic       last_tile;

  // rem_* hold rows/cols still to cover from the current tile onward
  assign rem_m_step = rem_m_q - AS10;
  assign rem_n_step = rem_n_q - AS10;
  assign last_tile  = (rem_m_q <= AS10) && (rem_n_q <= AS10);

  function automatic logic [7:0] clip(input logic [9:0] rem);
    return (rem > AS10) ? AS8 : rem[7:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    n_d        = n_q;
    rem_m_d    = rem_m_q;
    rem_n_d    = rem_n_q;
    zero_d     = zero_q;
    ack_cnt_d  = ack_cnt_q;
    err_d      = err_q;
    tpu_m_d    = tpu_m_q;
    tpu_n_d    = tpu_n_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    c_base_d   = c_base_q;
    tile_idx_d = tile_idx_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = ISSUE;
          err_d      = 1'b0;
          k_d        = cfg_k;
          n_d        = cfg_n;
          rem_m_d    = cfg_m;
          rem_n_d    = cfg_n;
          zero_d     = (cfg_k == 8'd0) || (cfg_m == 10'd0) || (cfg_n == 10'd0);
          tpu_m_d    = clip(cfg_m);
          tpu_n_d    = clip(cfg_n);
          a_base_d   = '0;
          b_base_d   = '0;
          c_base_d   = '0;
          tile_idx_d = '0;
        end
      end
      ISSUE: begin
        ack_cnt_d = 4'd0;
        if (zero_q) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tpu_busy) begin
          state_d = WAIT_DONE;
        end else if (ack_cnt_q == 4'd15) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else begin
          ack_cnt_d = ack_cnt_q + 4'd1;
        end
      end
      WAIT_DONE: begin
        if (!tpu_busy) state_d = NEXT;
      end
      NEXT: begin
        if (last_tile) begin
          state_d = FINISH;
        end else begin
          state_d    = ISSUE;
          tile_idx_d = tile_idx_q + 16'd1;
          c_base_d   = c_base_q + AS_ADR;
          if (rem_n_q > AS10) begin
            rem_n_d  = rem_n_step;
            tpu_n_d  = clip(rem_n_step);
            b_base_d = b_base_q + ADDR_BITS'(k_q);
          end else begin
            // column wrap: restart j and step one row of tiles down
            rem_n_d  = n_q;
            tpu_n_d  = clip(n_q);
            b_base_d = '0;
            rem_m_d  = rem_m_step;
            tpu_m_d  = clip(rem_m_step);
            a_base_d = a_base_q + ADDR_BITS'(k_q);
          end
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      n_q        <= '0;
      rem_m_q    <= '0;
      rem_n_q    <= '0;
      zero_q     <= 1'b0;
      ack_cnt_q  <= '0;
      err_q      <= 1'b0;
      tpu_m_q    <= '0;
      tpu_n_q    <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      c_base_q   <= '0;
      tile_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      n_q        <= n_d;
      rem_m_q    <= rem_m_d;
      rem_n_q    <= rem_n_d;
      zero_q     <= zero_d;
      ack_cnt_q  <= ack_cnt_d;
      err_q      <= err_d;
      tpu_m_q    <= tpu_m_d;
      tpu_n_q    <= tpu_n_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      c_base_q   <= c_base_d;
      tile_idx_q <= tile_idx_d;
    end
  end

  assign tpu_in_valid = (state_q == ISSUE) && !zero_q;
  assign done         = (state_q == FINISH);
  assign sched_busy   = (state_q != IDLE);
  assign err          = err_q;
  assign tpu_k        = k_q;
  assign tpu_m        = tpu_m_q;
  assign tpu_n        = tpu_n_q;
  assign a_base       = a_base_q;
  assign b_base       = b_base_q;
  assign c_base       = c_base_q;
  assign tile_idx     = tile_idx_q;

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// tb/tb_tpu_tile_scheduler.sv - randomized bench for tpu_tile_scheduler against a tile-list reference model.
module tb_tpu_tile_scheduler;
  localparam int A    = 4;
  localparam int AB   = 12;
  localparam int MASK = (1 << AB) - 1;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [7:0]    cfg_k;
  logic [9:0]    cfg_m, cfg_n;
  logic          model_busy = 1'b0, poke_busy = 1'b0;
  wire           tpu_busy = model_busy | poke_busy;
  logic          tpu_in_valid, sched_busy, done, err;
  logic [7:0]    tpu_k, tpu_m, tpu_n;
  logic [AB-1:0] a_base, b_base, c_base;
  logic [15:0]   tile_idx;

  int n_cmp = 0, n_bad = 0;

  typedef struct {int k; int m; int n; int a; int b; int c; int idx;} tile_t;
  tile_t obs_q[$];
  int    done_cnt = 0;
  bit    tpu_never = 1'b0;
  int    ack_dly = 0, busy_len = 0;

  always #5 clk = ~clk;

  tpu_tile_scheduler #(.ARRAY_SIZE(A), .ADDR_BITS(AB)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_k(cfg_k), .cfg_m(cfg_m), .cfg_n(cfg_n), .tpu_busy(tpu_busy),
    .tpu_in_valid(tpu_in_valid), .tpu_k(tpu_k), .tpu_m(tpu_m), .tpu_n(tpu_n),
    .a_base(a_base), .b_base(b_base), .c_base(c_base), .tile_idx(tile_idx),
    .sched_busy(sched_busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, 32'(tpu_in_valid), 0);
    check({tag, ".done"},  32'(done), 0);
    check({tag, ".busy"},  32'(sched_busy), 0);
    check({tag, ".err"},   32'(err), 0);
    check({tag, ".idx"},   32'(tile_idx), 0);
    check({tag, ".k"},     32'(tpu_k), 0);
    check({tag, ".m"},     32'(tpu_m), 0);
    check({tag, ".n"},     32'(tpu_n), 0);
    check({tag, ".a"},     32'(a_base), 0);
    check({tag, ".b"},     32'(b_base), 0);
    check({tag, ".c"},     32'(c_base), 0);
  endtask

  // Launch monitor: every cycle with tpu_in_valid high is one recorded launch
  initial forever begin
    @(posedge clk); #1;
    if (tpu_in_valid === 1'b1)
      obs_q.push_back('{int'(tpu_k), int'(tpu_m), int'(tpu_n), int'(a_base),
                        int'(b_base), int'(c_base), int'(tile_idx)});
    if (done === 1'b1) done_cnt++;
  end

  // TPU datapath model: raise busy some cycles after a launch, hold it, drop it
  initial begin
    int d, l;
    forever begin
      @(posedge clk); #1;
      if (tpu_in_valid === 1'b1 && !tpu_never) begin
        d = (ack_dly != 0) ? ack_dly : int'($urandom_range(1, 4));
        l = (busy_len != 0) ? busy_len : int'($urandom_range(1, 6));
        repeat (d) @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (l) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  task automatic run_job(input int k, input int m, input int n, input bit spam, input string tag);
    tile_t exp_q[$];
    tile_t t;
    int    mt, nt, cyc;
    bit    got;
    mt = (m + A - 1) / A;
    nt = (n + A - 1) / A;
    for (int i = 0; i < mt; i++) begin
      for (int j = 0; j < nt; j++) begin
        t.k   = k;
        t.m   = (m - A * i < A) ? m - A * i : A;
        t.n   = (n - A * j < A) ? n - A * j : A;
        t.idx = i * nt + j;
        t.a   = (i * k) & MASK;
        t.b   = (j * k) & MASK;
        t.c   = (t.idx * A) & MASK;
        exp_q.push_back(t);
      end
    end
    obs_q.delete();
    done_cnt = 0;
    cfg_k = 8'(k); cfg_m = 10'(m); cfg_n = 10'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".busy_rise"}, 32'(sched_busy), 1);
    check({tag, ".err_clr"}, 32'(err), 0);
    got = 1'b0;
    for (cyc = 0; cyc < 4000 && !got; cyc++) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        start = spam && ($urandom_range(0, 2) == 0);
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    check({tag, ".done_seen"}, 32'(got), 1);
    check({tag, ".busy_in_finish"}, 32'(sched_busy), 1);
    check({tag, ".err"}, 32'(err), 0);
    @(posedge clk); #1;
    check({tag, ".busy_fall"}, 32'(sched_busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check({tag, ".done_cnt"}, 32'(done_cnt), 1);
    check({tag, ".launches"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check($sformatf("%s.t%0d.k", tag, i),   obs_q[i].k,   exp_q[i].k);
      check($sformatf("%s.t%0d.m", tag, i),   obs_q[i].m,   exp_q[i].m);
      check($sformatf("%s.t%0d.n", tag, i),   obs_q[i].n,   exp_q[i].n);
      check($sformatf("%s.t%0d.a", tag, i),   obs_q[i].a,   exp_q[i].a);
      check($sformatf("%s.t%0d.b", tag, i),   obs_q[i].b,   exp_q[i].b);
      check($sformatf("%s.t%0d.c", tag, i),   obs_q[i].c,   exp_q[i].c);
      check($sformatf("%s.t%0d.idx", tag, i), obs_q[i].idx, exp_q[i].idx);
    end
  endtask

  initial begin
    int cyc, nl;
    reset = 1'b1; start = 1'b0; cfg_k = '0; cfg_m = '0; cfg_n = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // reset wins over a simultaneous start
    start = 1'b1; cfg_k = 8'd8; cfg_m = 10'd4; cfg_n = 10'd4;
    @(posedge clk); #1;
    check("rst_over_start.busy", 32'(sched_busy), 0);
    reset = 1'b0; start = 1'b0;

    // busy from the TPU while idle does nothing
    poke_busy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_busy.sched", 32'(sched_busy), 0);
    check("idle_busy.launch", 32'(obs_q.size()), 0);
    poke_busy = 1'b0;

    ack_dly = 1; busy_len = 10;
    run_job(8, 4, 4, 1'b0, "single");
    ack_dly = 0; busy_len = 0;
    run_job(3, 6, 9, 1'b0, "k3m6n9");

    // TPU never acknowledges: timeout after 16 waiting cycles, then FINISH
    tpu_never = 1'b1; obs_q.delete(); done_cnt = 0;
    cfg_k = 8'd8; cfg_m = 10'd4; cfg_n = 10'd8;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("timeout.launch", 32'(tpu_in_valid), 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("timeout.latency", cyc, 17);
    check("timeout.err", 32'(err), 1);
    repeat (4) @(posedge clk);
    #1;
    check("timeout.one_launch", 32'(obs_q.size()), 1);
    check("timeout.err_sticky", 32'(err), 1);
    tpu_never = 1'b0;

    // zero dimensions: no launch, error, done two cycles after start
    for (int z = 0; z < 3; z++) begin
      obs_q.delete();
      cfg_k = (z == 0) ? 8'd0 : 8'd5;
      cfg_m = (z == 1) ? 10'd0 : 10'd4;
      cfg_n = (z == 2) ? 10'd0 : 10'd4;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check($sformatf("zero%0d.busy", z), 32'(sched_busy), 1);
      check($sformatf("zero%0d.done_early", z), 32'(done), 0);
      @(posedge clk); #1;
      check($sformatf("zero%0d.done", z), 32'(done), 1);
      check($sformatf("zero%0d.err", z), 32'(err), 1);
      @(posedge clk); #1;
      check($sformatf("zero%0d.idle", z), 32'(sched_busy), 0);
      check($sformatf("zero%0d.launch", z), 32'(obs_q.size()), 0);
    end
    run_job(2, 5, 3, 1'b0, "err_clear");

    // reset in WAIT_DONE of the second tile
    ack_dly = 1; busy_len = 8;
    cfg_k = 8'd3; cfg_m = 10'd6; cfg_n = 10'd9;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nl = (tpu_in_valid === 1'b1) ? 1 : 0;
    cyc = 0;
    while (nl < 2 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (tpu_in_valid === 1'b1) nl++;
    end
    check("midrst.reached_tile2", nl, 2);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_outputs("midrst");
    cyc = 0;
    while (tpu_busy !== 1'b0 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("midrst.still_idle", 32'(sched_busy), 0);
    ack_dly = 0; busy_len = 0;
    run_job(3, 6, 9, 1'b0, "after_rst");

    run_job(3, 6, 9, 1'b1, "spam");

    for (int r = 0; r < 6; r++)
      run_job(int'($urandom_range(1, 255)), int'($urandom_range(1, 32)),
              int'($urandom_range(1, 32)), r[0], $sformatf("rand%0d", r));

    run_job(255, 81, 5, 1'b0, "addr_wrap");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
